// File: rtl/pid_sample_sequencer.sv
// rtl/pid_sample_sequencer.sv - periodic ap_start sequencer with overrun and hung-core detection for an HLS PID core
module pid_sample_sequencer #(
  parameter int DW      = 25,
  parameter int PW      = 16,
  parameter int TIMEOUT = 64,
  parameter int OVF_W   = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             enable,
  input  logic [PW-1:0]    period,
  input  logic [DW-1:0]    din0,
  input  logic [DW-1:0]    din1,
  input  logic             err_clr,
  input  logic             ovf_clr,
  output logic             core_ap_start,
  input  logic             core_ap_ready,
  input  logic             core_ap_done,
  output logic             core_rst,
  output logic             core_initn,
  output logic [DW-1:0]    core_din0,
  output logic [DW-1:0]    core_din1,
  input  logic [DW-1:0]    core_dout0,
  input  logic [DW-1:0]    core_dout1,
  output logic [DW-1:0]    dout0,
  output logic [DW-1:0]    dout1,
  output logic             dout_valid,
  output logic             busy,
  output logic             timeout_err,
  output logic [OVF_W-1:0] overrun_cnt,
  output logic [31:0]      sample_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_START,
    S_WAIT_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    plen_q, plen_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             first_run_q, first_run_d;
  logic [DW-1:0]    core_din0_q, core_din0_d;
  logic [DW-1:0]    core_din1_q, core_din1_d;
  logic [DW-1:0]    dout0_q, dout0_d;
  logic [DW-1:0]    dout1_q, dout1_d;
  logic             dout_valid_q, dout_valid_d;
  logic             timeout_err_q, timeout_err_d;
  logic [OVF_W-1:0] overrun_cnt_q, overrun_cnt_d;
  logic [31:0]      sample_cnt_q, sample_cnt_d;
  logic             core_ap_start_q, core_ap_start_d;
  logic             busy_q, busy_d;
  logic             core_rst_q, core_rst_d;
  logic             core_initn_q, core_initn_d;

  logic [PW-1:0]    period_eff;
  logic             in_txn;
  logic             cnt_run;
  logic             tick;
  logic             done_ev;
  logic             tmo_hit;

  // Decode of effective period, sample tick, core completion and timeout
  always_comb begin
    period_eff = (period == '0) ? PW'(1) : period;
    in_txn     = (state_q == S_START) || (state_q == S_WAIT_DONE);
    cnt_run    = enable && (state_q != S_IDLE) && (state_q != S_ERROR);
    tick       = cnt_run && (cnt_q == plen_q - PW'(1));
    // A core that raises ap_done together with ap_ready in START has completed
    done_ev    = core_ap_done &&
                 ((state_q == S_WAIT_DONE) || ((state_q == S_START) && core_ap_ready));
    tmo_hit    = in_txn && (tmo_q >= TW'(TIMEOUT - 1));
  end

  // Next-state, period/timeout counters, captures and registered outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    plen_d        = plen_q;
    tmo_d         = '0;
    first_run_d   = first_run_q;
    core_din0_d   = core_din0_q;
    core_din1_d   = core_din1_q;
    dout0_d       = dout0_q;
    dout1_d       = dout1_q;
    dout_valid_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    overrun_cnt_d = overrun_cnt_q;
    sample_cnt_d  = sample_cnt_q;

    // The period length is reloaded only at a wrap so a new period lands cleanly
    if (cnt_run) begin
      if (tick) begin
        cnt_d  = '0;
        plen_d = period_eff;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end

    if (in_txn) begin
      tmo_d = tmo_q + TW'(1);
    end

    // A tick landing while the core is busy is dropped and counted; clear wins
    if (ovf_clr) begin
      overrun_cnt_d = '0;
    end else if (tick && in_txn && (overrun_cnt_q != '1)) begin
      overrun_cnt_d = overrun_cnt_q + OVF_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_WAIT_TICK;
          first_run_d = 1'b1;
          cnt_d       = '0;
          plen_d      = period_eff;
        end
      end
      S_WAIT_TICK: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (tick) begin
          state_d     = S_START;
          core_din0_d = din0;
          core_din1_d = din1;
        end
      end
      S_START, S_WAIT_DONE: begin
        if (done_ev) begin
          dout0_d      = core_dout0;
          dout1_d      = core_dout1;
          dout_valid_d = 1'b1;
          sample_cnt_d = sample_cnt_q + 32'd1;
          first_run_d  = 1'b0;
          state_d      = enable ? S_WAIT_TICK : S_IDLE;
        end else if (tmo_hit) begin
          state_d       = S_ERROR;
          timeout_err_d = 1'b1;
        end else if ((state_q == S_START) && core_ap_ready) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_ERROR: begin
        if (err_clr) begin
          state_d       = S_IDLE;
          timeout_err_d = 1'b0;
          first_run_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Core-facing controls are registered from the next state to stay glitch-free
    core_ap_start_d = (state_d == S_START);
    busy_d          = (state_d == S_START) || (state_d == S_WAIT_DONE);
    core_rst_d      = (state_d == S_IDLE) || (state_d == S_ERROR);
    core_initn_d    = busy_d ? ~first_run_d : 1'b1;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      plen_q          <= PW'(1);
      tmo_q           <= '0;
      first_run_q     <= 1'b1;
      core_din0_q     <= '0;
      core_din1_q     <= '0;
      dout0_q         <= '0;
      dout1_q         <= '0;
      dout_valid_q    <= 1'b0;
      timeout_err_q   <= 1'b0;
      overrun_cnt_q   <= '0;
      sample_cnt_q    <= '0;
      core_ap_start_q <= 1'b0;
      busy_q          <= 1'b0;
      core_rst_q      <= 1'b1;
      core_initn_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      plen_q          <= plen_d;
      tmo_q           <= tmo_d;
      first_run_q     <= first_run_d;
      core_din0_q     <= core_din0_d;
      core_din1_q     <= core_din1_d;
      dout0_q         <= dout0_d;
      dout1_q         <= dout1_d;
      dout_valid_q    <= dout_valid_d;
      timeout_err_q   <= timeout_err_d;
      overrun_cnt_q   <= overrun_cnt_d;
      sample_cnt_q    <= sample_cnt_d;
      core_ap_start_q <= core_ap_start_d;
      busy_q          <= busy_d;
      core_rst_q      <= core_rst_d;
      core_initn_q    <= core_initn_d;
    end
  end

  assign core_ap_start = core_ap_start_q;
  assign core_rst      = core_rst_q;
  assign core_initn    = core_initn_q;
  assign core_din0     = core_din0_q;
  assign core_din1     = core_din1_q;
  assign dout0         = dout0_q;
  assign dout1         = dout1_q;
  assign dout_valid    = dout_valid_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;
  assign overrun_cnt   = overrun_cnt_q;
  assign sample_cnt    = sample_cnt_q;

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// tb/tb_pid_sample_sequencer.sv - scoreboard bench for pid_sample_sequencer with a behavioural PID core
module tb_pid_sample_sequencer;

  localparam int DW    = 25;
  localparam int PW    = 16;
  localparam int OVF_W = 8;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic             enable = 1'b0;
  logic [PW-1:0]    period = 16'd10;
  logic [DW-1:0]    din0 = '0;
  logic [DW-1:0]    din1 = '0;
  logic             err_clr = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             core_ap_start;
  logic             core_ap_ready = 1'b0;
  logic             core_ap_done = 1'b0;
  logic             core_rst;
  logic             core_initn;
  logic [DW-1:0]    core_din0;
  logic [DW-1:0]    core_din1;
  logic [DW-1:0]    core_dout0 = '0;
  logic [DW-1:0]    core_dout1 = '0;
  logic [DW-1:0]    dout0;
  logic [DW-1:0]    dout1;
  logic             dout_valid;
  logic             busy;
  logic             timeout_err;
  logic [OVF_W-1:0] overrun_cnt;
  logic [31:0]      sample_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_acc = 0;
  int lat = 3;
  bit hang = 1'b0;
  int chk_iv = 0;
  int chk_dov = 0;
  int first_req = 0;
  int first_seen = 0;
  bit m_busy = 1'b0;
  int m_cnt = 0;
  logic [2*DW-1:0] exp_q[$];

  pid_sample_sequencer dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .enable        (enable),
    .period        (period),
    .din0          (din0),
    .din1          (din1),
    .err_clr       (err_clr),
    .ovf_clr       (ovf_clr),
    .core_ap_start (core_ap_start),
    .core_ap_ready (core_ap_ready),
    .core_ap_done  (core_ap_done),
    .core_rst      (core_rst),
    .core_initn    (core_initn),
    .core_din0     (core_din0),
    .core_din1     (core_din1),
    .core_dout0    (core_dout0),
    .core_dout1    (core_dout1),
    .dout0         (dout0),
    .dout1         (dout1),
    .dout_valid    (dout_valid),
    .busy          (busy),
    .timeout_err   (timeout_err),
    .overrun_cnt   (overrun_cnt),
    .sample_cnt    (sample_cnt)
  );

  initial forever #5 HCLK = ~HCLK;

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural core transfer function; InitN=0 adds a visible offset
  function automatic logic [2*DW-1:0] pid_f(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic initn);
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    r0 = a + b + (initn ? 25'd0 : 25'h0100000);
    r1 = a ^ b ^ {24'd0, initn};
    return {r0, r1};
  endfunction

  // Sample-to-sample spacing: a sample occupies lat+1 busy cycles and restarts on the next tick
  function automatic int iv_of(input int p, input int l);
    int pe;
    pe = (p == 0) ? 1 : p;
    return pe * ((l + 2 + pe - 1) / pe);
  endfunction

  // Core model plus scoreboard, evaluated on the falling edge
  initial begin : core_model
    bit              have_prev;
    int              prev_cyc;
    logic [OVF_W-1:0] prev_ovf;
    logic [OVF_W-1:0] dov;
    logic [2*DW-1:0] e;
    bit              is_first;
    bit              accept;
    have_prev = 1'b0;
    prev_cyc  = 0;
    prev_ovf  = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        core_ap_done  = 1'b0;
        core_ap_ready = 1'b0;
        m_busy        = 1'b0;
        have_prev     = 1'b0;
        n_valid       = 0;
        exp_q.delete();
      end else begin
        if (dout_valid) begin
          n_valid++;
          chk("sb_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dout0", dout0, e[2*DW-1:DW]);
            chk("dout1", dout1, e[DW-1:0]);
          end
          chk("sample_cnt", sample_cnt, n_valid);
          if (chk_iv != 0) begin
            if (have_prev) chk("valid_interval", cyc - prev_cyc, chk_iv);
            dov = overrun_cnt - prev_ovf;
            chk("ovf_delta", dov, chk_dov);
          end
          have_prev = 1'b1;
          prev_cyc  = cyc;
          prev_ovf  = overrun_cnt;
        end
        if (chk_iv == 0) begin
          have_prev = 1'b0;
          prev_ovf  = overrun_cnt;
        end
        core_ap_done = 1'b0;
        if (m_busy) begin
          if (m_cnt <= 1) begin
            m_busy = 1'b0;
            if (!hang) begin
              core_ap_done = 1'b1;
              {core_dout0, core_dout1} = pid_f(core_din0, core_din1, core_initn);
            end
          end else begin
            m_cnt--;
          end
        end
        accept        = core_ap_start && !m_busy;
        core_ap_ready = !m_busy;
        if (accept) begin
          m_busy = 1'b1;
          m_cnt  = lat;
          n_acc++;
          if (!hang) begin
            is_first   = (first_req != first_seen);
            first_seen = first_req;
            exp_q.push_back(pid_f(din0, din1, !is_first));
          end
        end
      end
    end
  end

  task automatic wait_valids(input int n, input int budget);
    int target;
    int k;
    target = n_valid + n;
    k = 0;
    while (n_valid < target && k < budget) begin
      @(posedge HCLK); #2;
      k++;
    end
    if (n_valid < target) chk("wait_valid_budget", n_valid, target);
  endtask

  task automatic wait_accept(input int budget);
    int target;
    int k;
    target = n_acc + 1;
    k = 0;
    while (n_acc < target && k < budget) begin
      @(posedge HCLK); #2;
      k++;
    end
    if (n_acc < target) chk("wait_accept_budget", n_acc, target);
  endtask

  task automatic start_run(input int p, input int l, input bit check_rate);
    period  = PW'(p);
    lat     = l;
    ovf_clr = 1'b1;
    @(posedge HCLK); #2;
    ovf_clr = 1'b0;
    @(posedge HCLK); #2;
    chk_iv  = check_rate ? iv_of(p, l) : 0;
    chk_dov = check_rate ? (iv_of(p, l) / ((p == 0) ? 1 : p)) - 1 : 0;
    first_req++;
    enable = 1'b1;
  endtask

  task automatic stop_run();
    int k;
    k = 0;
    chk_iv = 0;
    enable = 1'b0;
    while (!(core_rst && !busy) && k < 300) begin
      @(posedge HCLK); #2;
      k++;
    end
    chk("stop_idle", core_rst && !busy, 1);
    repeat (2) begin @(posedge HCLK); #2; end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin : main
    int t_start;
    int t_err;
    int k;

    repeat (3) begin @(posedge HCLK); #2; end
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_initn", core_initn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ap_start", core_ap_start, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_overrun", overrun_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_dout0", dout0, 0);
    HRESETn = 1'b1;
    @(posedge HCLK); #2;
    chk("idle_hold", core_rst && !busy, 1);

    // Nominal sampling at period 10, done 3 cycles after ready
    din0 = 25'h0000111;
    din1 = 25'h0ABCDEF;
    start_run(10, 3, 1'b1);
    wait_valids(5, 120);
    chk("sample_cnt_5", sample_cnt, 5);

    // Snapshot holds while the live input moves mid-transaction
    din0 = 25'h0001234;
    wait_accept(40);
    @(posedge HCLK); #2;
    din0 = 25'h1FFFFFF;
    #1;
    chk("core_din0_hold", core_din0, 25'h0001234);
    wait_valids(2, 60);
    stop_run();

    // Period 4 against a 9-cycle core: two dropped ticks per sample
    start_run(4, 9, 1'b1);
    wait_valids(3, 80);
    chk_iv = 0;
    wait_accept(40);
    @(posedge HCLK); #2;
    @(posedge HCLK); #2;
    ovf_clr = 1'b1;
    @(posedge HCLK); #2;
    ovf_clr = 1'b0;
    chk("ovf_clr_wins", overrun_cnt, 0);
    wait_valids(1, 40);
    chk("ovf_after_clr", overrun_cnt, 1);
    stop_run();

    // Period 0 acts as 1: back-to-back starts, overruns counted while busy
    din1 = 25'h0000777;
    start_run(0, 3, 1'b1);
    wait_valids(4, 60);
    stop_run();
    start_run(0, 60, 1'b0);
    wait_valids(5, 600);
    chk("ovf_saturate", overrun_cnt, 255);
    stop_run();

    // Hung core: timeout 64 cycles after START, then recovery
    hang = 1'b1;
    start_run(10, 3, 1'b0);
    t_start = -1;
    t_err   = -1;
    k       = 0;
    while (t_err < 0 && k < 400) begin
      @(posedge HCLK); #2;
      k++;
      if (core_ap_start && t_start < 0) t_start = cyc;
      if (core_rst && t_start >= 0) t_err = cyc;
    end
    chk("timeout_cycles", t_err - t_start, 64);
    chk("timeout_err_set", timeout_err, 1);
    chk("error_core_rst", core_rst, 1);
    chk("error_busy", busy, 0);
    hang = 1'b0;
    repeat (5) begin @(posedge HCLK); #2; end
    chk("error_held", core_rst && timeout_err, 1);
    first_req++;
    err_clr = 1'b1;
    @(posedge HCLK); #2;
    err_clr = 1'b0;
    chk("timeout_err_clr", timeout_err, 0);
    wait_valids(2, 60);

    // Asynchronous reset in the middle of WAIT_DONE
    lat = 20;
    wait_accept(40);
    repeat (3) begin @(posedge HCLK); #2; end
    chk("busy_before_rst", busy, 1);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_core_rst", core_rst, 1);
    chk("arst_core_initn", core_initn, 0);
    chk("arst_ap_start", core_ap_start, 0);
    chk("arst_sample_cnt", sample_cnt, 0);
    chk("arst_dout0", dout0, 0);
    chk("arst_dout1", dout1, 0);
    chk("arst_core_din0", core_din0, 0);
    enable = 1'b0;
    repeat (20) @(posedge HCLK);
    #2;
    HRESETn = 1'b1;
    repeat (6) begin @(posedge HCLK); #2; end
    chk("post_rst_idle", core_rst && !busy && !core_ap_start, 1);
    chk("post_rst_samples", sample_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
